// File: rtl/ahb_sram_snap_slave.sv
// rtl/ahb_sram_snap_slave.sv - parametrised AHB-Lite SRAM slave with wait states, ERROR response and snapshot port
//
// Ports:
//   hclk, hresetn        clock, asynchronous active-low reset
//   hsel .. hwdata       AHB-Lite slave inputs (word addressed, no byte lanes)
//   hreadyout, hresp     slave ready and OKAY(0)/ERROR(1) response
//   hrdata               read data, registered, valid for the read completion cycle
//   confirm              asynchronous pushbutton, active-high
//   snap_addr            address to capture on a confirm rising edge
//   snap_data            captured word (0 when out of range)
//   snap_addr_q          captured address
//   snap_err             captured address was out of range
module ahb_sram_snap_slave #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    input  logic              confirm,
    input  logic [ADDR_W-1:0] snap_addr,
    output logic [DATA_W-1:0] snap_data,
    output logic [ADDR_W-1:0] snap_addr_q,
    output logic              snap_err
);

    localparam int              MAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [2:0]      WS      = 3'(WAIT_STATES);
    localparam logic [10:0]     DW_L    = 11'(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t            state, state_nxt;
    logic [2:0]        wcnt;
    logic              live;        // legal access currently in its data phase
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic              sync1, sync2, sync3;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept, illegal, complete, commit, snap_edge, snap_in_range;
    logic [10:0]       size_bits;
    logic              unused_htrans0;

    assign unused_htrans0 = htrans[0];

    // hreadyout is folded in so a misbehaving master cannot start a transfer
    // while this slave is still stalling its own data phase.
    assign accept        = hsel & hready & htrans[1] & hreadyout;
    assign size_bits     = 11'd8 << hsize;
    assign illegal       = ({1'b0, haddr} >= DEPTH_L) | (size_bits > DW_L);
    assign complete      = live & hreadyout;
    assign commit        = complete & write_q;
    assign snap_edge     = sync2 & ~sync3;
    assign snap_in_range = ({1'b0, snap_addr} < DEPTH_L);

    // State register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic: any ready cycle (IDLE, ERR2, WAIT completion) can take a new accept.
    always_comb begin
        state_nxt = state;
        if (hreadyout) begin
            if (accept) begin
                if (illegal)              state_nxt = S_ERR1;
                else if (WAIT_STATES > 0) state_nxt = S_WAIT;
                else                      state_nxt = S_IDLE;
            end else begin
                state_nxt = S_IDLE;
            end
        end else if (state == S_ERR1) begin
            state_nxt = S_ERR2;
        end
    end

    // Outputs: WAIT stalls until the counter reaches WS; that last cycle is the completion.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            S_WAIT: hreadyout = (wcnt == WS);
            S_ERR1: begin hreadyout = 1'b0; hresp = 1'b1; end
            S_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wcnt        <= 3'd0;
            live        <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            hrdata      <= '0;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            snap_data   <= '0;
            snap_addr_q <= '0;
            snap_err    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= haddr;
                write_q <= hwrite;
                live    <= ~illegal;
                wcnt    <= 3'd0;
            end else begin
                if (complete) live <= 1'b0;
                if (state == S_WAIT && wcnt != WS) wcnt <= wcnt + 3'd1;
            end

            // hrdata is loaded on the edge that opens the read completion cycle.
            // With no wait states that is the accept edge itself, where a write
            // to the same address may be committing, so forward hwdata.
            if (accept && illegal) begin
                hrdata <= '0;
            end else if (accept && !hwrite && WAIT_STATES == 0) begin
                hrdata <= (commit && addr_q == haddr) ? hwdata : mem[haddr[MAW-1:0]];
            end else if (state == S_WAIT && !write_q && wcnt == WS - 3'd1) begin
                hrdata <= mem[addr_q[MAW-1:0]];
            end

            sync1 <= confirm;
            sync2 <= sync1;
            sync3 <= sync2;
            if (snap_edge) begin
                snap_addr_q <= snap_addr;
                if (snap_in_range) begin
                    snap_data <= (commit && addr_q == snap_addr) ? hwdata
                                                                 : mem[snap_addr[MAW-1:0]];
                    snap_err  <= 1'b0;
                end else begin
                    snap_data <= '0;
                    snap_err  <= 1'b1;
                end
            end
        end
    end

    // Memory array is intentionally not reset; live is, so a reset drops any pending write.
    always_ff @(posedge hclk) begin
        if (commit) mem[addr_q[MAW-1:0]] <= hwdata;
    end

endmodule

// File: tb/tb_ahb_sram_snap_slave.sv
// tb/tb_ahb_sram_snap_slave.sv - directed self-checking bench for ahb_sram_snap_slave
module tb_ahb_sram_snap_slave;

    logic       hclk = 1'b0;
    logic       hresetn;
    logic       hsel_b;
    logic       hwrite;
    logic [9:0] haddr;
    logic [2:0] hsize;
    logic [1:0] htrans;
    logic [7:0] hwdata;
    logic       confirm;
    logic [9:0] snap_addr;
    int         sel;

    logic       hro [2];
    logic       hrs [2];
    logic [7:0] hrd [2];
    logic [7:0] sd  [2];
    logic [9:0] saq [2];
    logic       se  [2];
    logic       hsel0, hsel1;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 hclk = ~hclk;

    assign hsel0 = hsel_b & (sel == 0);
    assign hsel1 = hsel_b & (sel == 1);

    ahb_sram_snap_slave #(.DATA_W(8), .ADDR_W(10), .DEPTH(512), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .htrans(htrans), .hready(hro[0]), .hwdata(hwdata),
        .hreadyout(hro[0]), .hresp(hrs[0]), .hrdata(hrd[0]), .confirm(confirm),
        .snap_addr(snap_addr), .snap_data(sd[0]), .snap_addr_q(saq[0]), .snap_err(se[0])
    );

    ahb_sram_snap_slave #(.DATA_W(8), .ADDR_W(10), .DEPTH(512), .WAIT_STATES(3)) u_dut3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .htrans(htrans), .hready(hro[1]), .hwdata(hwdata),
        .hreadyout(hro[1]), .hresp(hrs[1]), .hrdata(hrd[1]), .confirm(confirm),
        .snap_addr(snap_addr), .snap_data(sd[1]), .snap_addr_q(saq[1]), .snap_err(se[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer with idle bus around it; counts hreadyout-low data cycles.
    task automatic xfer(input string tag, input bit wr, input logic [9:0] a, input logic [7:0] wd,
                        input logic [2:0] sz, input int exp_low, input bit exp_err,
                        input bit chk_rd, input logic [7:0] exp_rd);
        int lows = 0;
        @(negedge hclk);
        hsel_b = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
        @(negedge hclk);
        hsel_b = 1'b0; htrans = 2'b00; hwdata = wd;
        while (hro[sel] == 1'b0 && lows < 20) begin
            chk({tag, "_resp_low"}, 32'(hrs[sel]), 32'(exp_err));
            lows++;
            @(negedge hclk);
        end
        chk({tag, "_lows"}, lows, exp_low);
        chk({tag, "_resp"}, 32'(hrs[sel]), 32'(exp_err));
        if (chk_rd) chk({tag, "_rdata"}, 32'(hrd[sel]), 32'(exp_rd));
    endtask

    task automatic snap(input string tag, input logic [9:0] a, input logic [7:0] exp_d, input bit exp_e);
        @(negedge hclk);
        snap_addr = a; confirm = 1'b1;
        repeat (5) @(negedge hclk);
        snap_addr = a ^ 10'd1;          // a second capture would pick this up
        repeat (5) @(negedge hclk);
        confirm = 1'b0;
        repeat (4) @(negedge hclk);
        chk({tag, "_data"}, 32'(sd[0]), 32'(exp_d));
        chk({tag, "_addr"}, 32'(saq[0]), 32'(a));
        chk({tag, "_err"},  32'(se[0]), 32'(exp_e));
    endtask

    initial begin
        hresetn = 1'b0; hsel_b = 1'b0; hwrite = 1'b0; haddr = '0; hsize = 3'd0;
        htrans = 2'b00; hwdata = '0; confirm = 1'b0; snap_addr = '0; sel = 0;
        repeat (3) @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);
        chk("rst_hreadyout", 32'(hro[0]), 32'd1);
        chk("rst_hresp",     32'(hrs[0]), 32'd0);
        chk("rst_hrdata",    32'(hrd[0]), 32'd0);
        chk("rst_snap_data", 32'(sd[0]),  32'd0);
        chk("rst_snap_addr", 32'(saq[0]), 32'd0);
        chk("rst_snap_err",  32'(se[0]),  32'd0);

        // Zero wait states
        xfer("w3",  1'b1, 10'd3, 8'hA5, 3'd0, 0, 1'b0, 1'b0, 8'h00);
        xfer("r3",  1'b0, 10'd3, 8'h00, 3'd0, 0, 1'b0, 1'b1, 8'hA5);
        xfer("w88", 1'b1, 10'd88, 8'h3C, 3'd0, 0, 1'b0, 1'b0, 8'h00);

        // Illegal accesses: out-of-range address (aliases 88 if truncated) and oversize
        xfer("e600", 1'b1, 10'd600, 8'hFF, 3'd0, 1, 1'b1, 1'b1, 8'h00);
        xfer("r88",  1'b0, 10'd88,  8'h00, 3'd0, 0, 1'b0, 1'b1, 8'h3C);
        xfer("esz",  1'b1, 10'd88,  8'hEE, 3'd1, 1, 1'b1, 1'b1, 8'h00);
        xfer("r88b", 1'b0, 10'd88,  8'h00, 3'd0, 0, 1'b0, 1'b1, 8'h3C);

        // Back-to-back write then read of address 5 (forwarding)
        @(negedge hclk);
        hsel_b = 1'b1; htrans = 2'b10; haddr = 10'd5; hwrite = 1'b1; hsize = 3'd0;
        @(negedge hclk);
        chk("b2b_w_ready", 32'(hro[0]), 32'd1);
        hwdata = 8'h11; hwrite = 1'b0;
        @(negedge hclk);
        hsel_b = 1'b0; htrans = 2'b00;
        chk("b2b_r_ready", 32'(hro[0]), 32'd1);
        chk("b2b_r_resp",  32'(hrs[0]), 32'd0);
        chk("b2b_r_data",  32'(hrd[0]), 32'h11);
        repeat (2) @(negedge hclk);
        chk("idle_ready", 32'(hro[0]), 32'd1);
        chk("idle_resp",  32'(hrs[0]), 32'd0);
        chk("idle_hold",  32'(hrd[0]), 32'h11);

        // Snapshot port
        snap("snap5",   10'd5,   8'h11, 1'b0);
        snap("snap700", 10'd700, 8'h00, 1'b1);
        snap("snap3",   10'd3,   8'hA5, 1'b0);

        // Three wait states
        sel = 1;
        xfer("ws_w7", 1'b1, 10'd7, 8'h5A, 3'd0, 3, 1'b0, 1'b0, 8'h00);
        xfer("ws_r7", 1'b0, 10'd7, 8'h00, 3'd0, 3, 1'b0, 1'b1, 8'h5A);
        xfer("ws_w9", 1'b1, 10'd9, 8'h22, 3'd0, 3, 1'b0, 1'b0, 8'h00);

        // Reset during the wait of a write to address 9
        @(negedge hclk);
        hsel_b = 1'b1; htrans = 2'b10; haddr = 10'd9; hwrite = 1'b1; hsize = 3'd0;
        @(negedge hclk);
        hsel_b = 1'b0; htrans = 2'b00; hwdata = 8'h99;
        chk("mid_wait_low", 32'(hro[1]), 32'd0);
        @(negedge hclk);
        hresetn = 1'b0;
        @(negedge hclk);
        chk("mrst_hreadyout", 32'(hro[1]), 32'd1);
        chk("mrst_hresp",     32'(hrs[1]), 32'd0);
        chk("mrst_hrdata",    32'(hrd[1]), 32'd0);
        chk("mrst_snap_data", 32'(sd[0]),  32'd0);
        chk("mrst_snap_addr", 32'(saq[0]), 32'd0);
        chk("mrst_snap_err",  32'(se[0]),  32'd0);
        hresetn = 1'b1;
        xfer("ws_r9", 1'b0, 10'd9, 8'h00, 3'd0, 3, 1'b0, 1'b1, 8'h22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
